// File: rtl/regfile_wb_arbiter_if.sv
// Bus bundle between the pipeline/MD unit and the register-file write-port arbiter.
// MD handshake: an MD result transfers at a rising edge where md_valid && md_ready;
// md_addr/md_data must be stable while md_valid is high. WB has no backpressure.
interface regfile_wb_arbiter_if;
  logic        wb_valid;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        md_valid;
  logic        md_ready;
  logic [4:0]  md_addr;
  logic [31:0] md_data;
  logic        pipe_stall;
  logic [31:0] md_pending_mask;
  logic        rf_we;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;

  modport master (
    output wb_valid, wb_addr, wb_data, md_valid, md_addr, md_data,
    input  md_ready, pipe_stall, md_pending_mask, rf_we, rf_addr, rf_data
  );

  modport slave (
    input  wb_valid, wb_addr, wb_data, md_valid, md_addr, md_data,
    output md_ready, pipe_stall, md_pending_mask, rf_we, rf_addr, rf_data
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: WB has priority, MD results queue in a FIFO,
// and a starvation counter forces a one-cycle pipeline stall so MD always drains.
module regfile_wb_arbiter #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  regfile_wb_arbiter_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic {ARB_RUN, ARB_STALL} arb_state_e;

  arb_state_e        state_q, state_d;
  logic [CW-1:0]     starve_cnt, starve_cnt_d;
  logic [AW:0]       wr_ptr, rd_ptr;
  logic [4:0]        addr_q [DEPTH];
  logic [31:0]       data_q [DEPTH];
  logic [DEPTH-1:0]  vld_q;
  logic              empty, full, push, pop, gnt_wb, gnt_md;
  logic [AW-1:0]     wr_idx, rd_idx;
  logic [31:0]       pending;

  assign wr_idx = wr_ptr[AW-1:0];
  assign rd_idx = rd_ptr[AW-1:0];
  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_idx == rd_idx);

  // Acceptance depends only on occupancy at the start of the cycle: no push-through.
  assign bus.md_ready = rst_n && !full;
  assign push         = bus.md_valid && bus.md_ready;

  // The stall state is the arbiter's only FSM state and is visible as pipe_stall.
  assign bus.pipe_stall = (state_q == ARB_STALL);
  assign gnt_wb         = bus.wb_valid && (state_q != ARB_STALL);
  assign gnt_md         = !gnt_wb && !empty;
  assign pop            = gnt_md;

  always_comb begin
    state_d      = ARB_RUN;
    starve_cnt_d = starve_cnt;
    if (pop || empty) begin
      starve_cnt_d = '0;
    end else if (gnt_wb) begin
      starve_cnt_d = starve_cnt + 1'b1;
    end
    if (state_q == ARB_RUN && gnt_wb && !empty && starve_cnt_d == CW'(STARVE_LIMIT)) begin
      state_d = ARB_STALL;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ARB_RUN;
      starve_cnt <= '0;
    end else begin
      state_q    <= state_d;
      starve_cnt <= starve_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      vld_q  <= '0;
    end else begin
      if (push) begin
        addr_q[wr_idx] <= bus.md_addr;
        data_q[wr_idx] <= bus.md_data;
        vld_q[wr_idx]  <= 1'b1;
        wr_ptr         <= wr_ptr + 1'b1;
      end
      if (pop) begin
        vld_q[rd_idx] <= 1'b0;
        rd_ptr        <= rd_ptr + 1'b1;
      end
    end
  end

  always_comb begin
    pending = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i]) pending[addr_q[i]] = 1'b1;
    end
    pending[0] = 1'b0;
  end
  assign bus.md_pending_mask = pending;

  // Writes to $zero still consume their grant but never raise the strobe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.rf_we   <= 1'b0;
      bus.rf_addr <= '0;
      bus.rf_data <= '0;
    end else begin
      bus.rf_we <= 1'b0;
      if (gnt_wb) begin
        bus.rf_we   <= (bus.wb_addr != 5'd0);
        bus.rf_addr <= bus.wb_addr;
        bus.rf_data <= bus.wb_data;
      end else if (gnt_md) begin
        bus.rf_we   <= (addr_q[rd_idx] != 5'd0);
        bus.rf_addr <= addr_q[rd_idx];
        bus.rf_data <= data_q[rd_idx];
      end
    end
  end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: hand-computed vectors plus an
// expected-write queue that every register-file strobe is compared against.
module tb_regfile_wb_arbiter;
  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;
  logic [36:0] exp_q[$];

  regfile_wb_arbiter_if bus ();

  regfile_wb_arbiter #(.DEPTH(2), .STARVE_LIMIT(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_wb(input logic v, input logic [4:0] a, input logic [31:0] d);
    bus.wb_valid = v;
    bus.wb_addr  = a;
    bus.wb_data  = d;
  endtask

  task automatic drive_md(input logic v, input logic [4:0] a, input logic [31:0] d);
    bus.md_valid = v;
    bus.md_addr  = a;
    bus.md_data  = d;
  endtask

  task automatic expect_write(input logic [4:0] a, input logic [31:0] d);
    exp_q.push_back({a, d});
  endtask

  // Scoreboard: every strobed write must match the head of the expected queue
  always @(posedge clk) begin
    logic [36:0] e;
    #1;
    if (bus.rf_we) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_write", {27'd0, bus.rf_addr}, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check_eq("sb_addr", {27'd0, bus.rf_addr}, {27'd0, e[36:32]});
        check_eq("sb_data", bus.rf_data, e[31:0]);
      end
    end
  end

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst_n    = 1'b0;
    drive_wb(1'b0, 5'd0, 32'd0);
    drive_md(1'b0, 5'd0, 32'd0);
    tick();
    tick();

    // Reset state
    check_eq("rst_rf_we", {31'd0, bus.rf_we}, 32'd0);
    check_eq("rst_rf_addr", {27'd0, bus.rf_addr}, 32'd0);
    check_eq("rst_rf_data", bus.rf_data, 32'd0);
    check_eq("rst_stall", {31'd0, bus.pipe_stall}, 32'd0);
    check_eq("rst_mask", bus.md_pending_mask, 32'd0);
    check_eq("rst_md_ready_low", {31'd0, bus.md_ready}, 32'd0);
    rst_n = 1'b1;
    tick();
    check_eq("md_ready_after_rst", {31'd0, bus.md_ready}, 32'd1);

    // 1: WB only
    drive_wb(1'b1, 5'd5, 32'hDEAD_BEEF);
    expect_write(5'd5, 32'hDEAD_BEEF);
    tick();
    drive_wb(1'b0, 5'd0, 32'd0);
    check_eq("t1_we", {31'd0, bus.rf_we}, 32'd1);
    check_eq("t1_addr", {27'd0, bus.rf_addr}, 32'd5);
    check_eq("t1_data", bus.rf_data, 32'hDEAD_BEEF);
    tick();
    check_eq("t1_we_idle", {31'd0, bus.rf_we}, 32'd0);
    check_eq("t1_addr_hold", {27'd0, bus.rf_addr}, 32'd5);

    // 2: MD only, one cycle through the FIFO
    drive_md(1'b1, 5'd3, 32'h1234_5678);
    expect_write(5'd3, 32'h1234_5678);
    tick();
    drive_md(1'b0, 5'd0, 32'd0);
    check_eq("t2_mask_pending", bus.md_pending_mask, 32'h8);
    check_eq("t2_we_not_yet", {31'd0, bus.rf_we}, 32'd0);
    tick();
    check_eq("t2_we", {31'd0, bus.rf_we}, 32'd1);
    check_eq("t2_addr", {27'd0, bus.rf_addr}, 32'd3);
    check_eq("t2_mask_clear", bus.md_pending_mask, 32'd0);
    tick();

    // 3: starvation forces one stall cycle that drains MD
    drive_wb(1'b1, 5'd1, 32'h100);
    drive_md(1'b1, 5'd10, 32'hA0A0_A0A0);
    expect_write(5'd1, 32'h100);
    tick();
    drive_md(1'b0, 5'd0, 32'd0);
    check_eq("t3_mask", bus.md_pending_mask, 32'h400);
    for (int k = 1; k <= 4; k++) begin
      drive_wb(1'b1, 5'd1, 32'h100 + k);
      expect_write(5'd1, 32'h100 + k);
      tick();
      check_eq("t3_stall", {31'd0, bus.pipe_stall}, (k == 4) ? 32'd1 : 32'd0);
    end
    drive_wb(1'b1, 5'd1, 32'h105);
    expect_write(5'd10, 32'hA0A0_A0A0);
    tick();
    check_eq("t3_stall_drop", {31'd0, bus.pipe_stall}, 32'd0);
    check_eq("t3_md_addr", {27'd0, bus.rf_addr}, 32'd10);
    check_eq("t3_mask_clear", bus.md_pending_mask, 32'd0);
    expect_write(5'd1, 32'h105);
    tick();
    check_eq("t3_wb_resume", bus.rf_data, 32'h105);
    drive_wb(1'b0, 5'd0, 32'd0);
    tick();

    // 4: FIFO full, pushes refused, no push-through on a pop
    drive_wb(1'b1, 5'd2, 32'h200);
    drive_md(1'b1, 5'd7, 32'h7);
    expect_write(5'd2, 32'h200);
    tick();
    drive_wb(1'b1, 5'd2, 32'h201);
    drive_md(1'b1, 5'd9, 32'h9);
    expect_write(5'd2, 32'h201);
    tick();
    check_eq("t4_ready_full", {31'd0, bus.md_ready}, 32'd0);
    check_eq("t4_mask_full", bus.md_pending_mask, 32'h280);
    drive_wb(1'b1, 5'd2, 32'h202);
    drive_md(1'b1, 5'd11, 32'hB);
    expect_write(5'd2, 32'h202);
    tick();
    check_eq("t4_refused", bus.md_pending_mask, 32'h280);
    drive_wb(1'b0, 5'd0, 32'd0);
    expect_write(5'd7, 32'h7);
    tick();
    check_eq("t4_no_push_through", bus.md_pending_mask, 32'h200);
    drive_md(1'b0, 5'd0, 32'd0);
    expect_write(5'd9, 32'h9);
    tick();
    check_eq("t4_drained", bus.md_pending_mask, 32'd0);
    tick();

    // 5: $zero writes
    drive_wb(1'b1, 5'd0, 32'hFFFF_FFFF);
    tick();
    drive_wb(1'b0, 5'd0, 32'd0);
    check_eq("t5_wb_zero_we", {31'd0, bus.rf_we}, 32'd0);
    drive_md(1'b1, 5'd0, 32'h55);
    tick();
    drive_md(1'b0, 5'd0, 32'd0);
    check_eq("t5_mask_zero", bus.md_pending_mask, 32'd0);
    tick();
    check_eq("t5_md_zero_we", {31'd0, bus.rf_we}, 32'd0);
    tick();

    // 6: reset while two entries are queued and the stall is asserted
    drive_md(1'b1, 5'd12, 32'hC);
    for (int k = 0; k < 5; k++) begin
      drive_wb(1'b1, 5'd4, 32'h400 + k);
      expect_write(5'd4, 32'h400 + k);
      if (k == 1) drive_md(1'b1, 5'd13, 32'hD);
      if (k == 2) drive_md(1'b0, 5'd0, 32'd0);
      tick();
    end
    check_eq("t6_stall", {31'd0, bus.pipe_stall}, 32'd1);
    check_eq("t6_mask", bus.md_pending_mask, 32'h3000);
    rst_n = 1'b0;
    drive_wb(1'b0, 5'd0, 32'd0);
    tick();
    check_eq("t6_rst_we", {31'd0, bus.rf_we}, 32'd0);
    check_eq("t6_rst_addr", {27'd0, bus.rf_addr}, 32'd0);
    check_eq("t6_rst_data", bus.rf_data, 32'd0);
    check_eq("t6_rst_stall", {31'd0, bus.pipe_stall}, 32'd0);
    check_eq("t6_rst_mask", bus.md_pending_mask, 32'd0);
    rst_n = 1'b1;
    tick();
    check_eq("t6_no_stale_we", {31'd0, bus.rf_we}, 32'd0);
    check_eq("t6_ready", {31'd0, bus.md_ready}, 32'd1);
    tick();
    check_eq("t6_no_stale_we2", {31'd0, bus.rf_we}, 32'd0);

    check_eq("sb_queue_empty", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
